firebird_alu_arbiter: RTL and testbench

- Shares one combinational ALU between two requesters using valid/ready handshakes.
- Requester 0 is the main execute path; requester 1 is the auxiliary path (branch-target / address calculation in the multi-cycle build).
- Grants round-robin, registers the operands into the ALU, captures the result and returns it on a per-requester response channel.
- One transaction is outstanding at a time.

---
 rtl/firebird_alu_defs.sv | 17 +
 rtl/firebird_rr_arb2.sv | 26 ++
 rtl/firebird_alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_firebird_alu_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/firebird_alu_defs.sv
// Shared definitions for the firebird ALU arbiter: ALU codes, FSM states, default width.
package firebird_alu_defs;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/firebird_rr_arb2.sv
// Two-input round-robin grant: lone requester wins, a tie goes to the one not served last.
module firebird_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    input  logic update,
    output logic grant
);

    logic last_grant_q;

    always_comb begin
        grant = (valid0 && valid1) ? ~last_grant_q : valid1;
    end

    // Reset value 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (update) begin
            last_grant_q <= grant;
        end
    end

endmodule

// File: rtl/firebird_alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters, one transaction at a time.
// Optional performance counters are enabled with `define FIREBIRD_ALU_ARB_PERF_EN.
module firebird_alu_arbiter
    import firebird_alu_defs::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_ctrl,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_ctrl,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic [3:0]      alu_ctrl_signal,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,
    output logic            rsp0_zero,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result,
    output logic            rsp1_zero
`ifdef FIREBIRD_ALU_ARB_PERF_EN
    ,
    output logic [31:0]     perf_grant0,
    output logic [31:0]     perf_grant1,
    output logic [31:0]     perf_conflict
`endif
);

    arb_state_e      state_q, state_d;
    logic            owner_q;
    logic            grant;
    logic            req_hs;
    logic [3:0]      alu_ctrl_q;
    logic [XLEN-1:0] alu_a_q, alu_b_q;
    logic [XLEN-1:0] res0_q, res1_q;
    logic            zero0_q, zero1_q;

    firebird_rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .update (req_hs),
        .grant  (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_hs) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is gated by rst_n so it reads 0 while reset is held, even with valids high.
    always_comb begin
        req0_ready = rst_n && (state_q == IDLE) && !grant && req0_valid;
        req1_ready = rst_n && (state_q == IDLE) &&  grant && req1_valid;
        req_hs     = req0_ready || req1_ready;
        rsp0_valid = (state_q == RESP) && !owner_q;
        rsp1_valid = (state_q == RESP) &&  owner_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= 1'b0;
            alu_ctrl_q <= ALU_ADD;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            res0_q     <= '0;
            res1_q     <= '0;
            zero0_q    <= 1'b0;
            zero1_q    <= 1'b0;
        end else begin
            if (req_hs) begin
                owner_q    <= grant;
                alu_ctrl_q <= grant ? req1_ctrl : req0_ctrl;
                alu_a_q    <= grant ? req1_a    : req0_a;
                alu_b_q    <= grant ? req1_b    : req0_b;
            end
            // Only the owner's response registers move; the other side keeps stale data.
            if (state_q == EXEC) begin
                if (owner_q) begin
                    res1_q  <= alu_result;
                    zero1_q <= alu_zero;
                end else begin
                    res0_q  <= alu_result;
                    zero0_q <= alu_zero;
                end
            end
        end
    end

    assign alu_ctrl_signal = alu_ctrl_q;
    assign alu_a           = alu_a_q;
    assign alu_b           = alu_b_q;
    assign rsp0_result     = res0_q;
    assign rsp0_zero       = zero0_q;
    assign rsp1_result     = res1_q;
    assign rsp1_zero       = zero1_q;

`ifdef FIREBIRD_ALU_ARB_PERF_EN
    logic [31:0] perf_grant0_q, perf_grant1_q, perf_conflict_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant0_q   <= '0;
            perf_grant1_q   <= '0;
            perf_conflict_q <= '0;
        end else begin
            if (req0_ready) perf_grant0_q <= perf_grant0_q + 32'd1;
            if (req1_ready) perf_grant1_q <= perf_grant1_q + 32'd1;
            if ((state_q == IDLE) && req0_valid && req1_valid)
                perf_conflict_q <= perf_conflict_q + 32'd1;
        end
    end

    assign perf_grant0   = perf_grant0_q;
    assign perf_grant1   = perf_grant1_q;
    assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_firebird_alu_arbiter.sv
// Self-checking bench for firebird_alu_arbiter: directed scenarios plus random traffic vs. a transaction model.
module tb_firebird_alu_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]      req0_ctrl, req1_ctrl, alu_ctrl_signal;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
    logic            alu_zero;
    logic            rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready, rsp0_zero, rsp1_zero;
    logic [XLEN-1:0] rsp0_result, rsp1_result;
`ifdef FIREBIRD_ALU_ARB_PERF_EN
    logic [31:0]     perf_grant0, perf_grant1, perf_conflict;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    firebird_alu_arbiter #(.XLEN(XLEN)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req0_valid      (req0_valid),
        .req0_ready      (req0_ready),
        .req0_ctrl       (req0_ctrl),
        .req0_a          (req0_a),
        .req0_b          (req0_b),
        .req1_valid      (req1_valid),
        .req1_ready      (req1_ready),
        .req1_ctrl       (req1_ctrl),
        .req1_a          (req1_a),
        .req1_b          (req1_b),
        .alu_ctrl_signal (alu_ctrl_signal),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_result      (alu_result),
        .alu_zero        (alu_zero),
        .rsp0_valid      (rsp0_valid),
        .rsp0_ready      (rsp0_ready),
        .rsp0_result     (rsp0_result),
        .rsp0_zero       (rsp0_zero),
        .rsp1_valid      (rsp1_valid),
        .rsp1_ready      (rsp1_ready),
        .rsp1_result     (rsp1_result),
        .rsp1_zero       (rsp1_zero)
`ifdef FIREBIRD_ALU_ARB_PERF_EN
        ,
        .perf_grant0     (perf_grant0),
        .perf_grant1     (perf_grant1),
        .perf_conflict   (perf_conflict)
`endif
    );

    function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            default: return a ^ ~b;
        endcase
    endfunction

    // Stub ALU driven from the DUT's registered operands.
    always_comb begin
        alu_result = ref_alu(alu_ctrl_signal, alu_a, alu_b);
        alu_zero   = (alu_result == '0);
    end

    // Transaction model: phase 0 = waiting for a request, 1 = operation in flight, 2 = result offered.
    int              m_phase;
    logic            m_owner, m_last;
    logic [3:0]      m_ctrl;
    logic [XLEN-1:0] m_a, m_b;
    logic [XLEN-1:0] m_res [2];
    logic            m_zero [2];
    int unsigned     m_g0, m_g1, m_conf;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_owner = 1'b0; m_last = 1'b1;
        m_ctrl = 4'b0010; m_a = '0; m_b = '0;
        m_res[0] = '0; m_res[1] = '0; m_zero[0] = 1'b0; m_zero[1] = 1'b0;
        m_g0 = 0; m_g1 = 0; m_conf = 0;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        check_eq("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        check_eq("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check_eq("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        check_eq("rst_alu_ctrl", {28'd0, alu_ctrl_signal}, 32'h2);
        check_eq("rst_alu_a", alu_a, 32'd0);
        check_eq("rst_alu_b", alu_b, 32'd0);
        check_eq("rst_rsp0_result", rsp0_result, 32'd0);
        check_eq("rst_rsp1_zero", {31'd0, rsp1_zero}, 32'd0);
    endtask

    // Assert reset between edges, check outputs immediately, release on a later falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive on the falling edge, check vs. model, advance the model at the rising edge.
    task automatic cycle(input logic v0, input logic v1,
                         input logic [3:0] c0, input logic [XLEN-1:0] a0, input logic [XLEN-1:0] b0,
                         input logic [3:0] c1, input logic [XLEN-1:0] a1, input logic [XLEN-1:0] b1,
                         input logic r0, input logic r1);
        logic g, e_r0, e_r1, e_v0, e_v1;
        @(negedge clk);
        req0_valid = v0; req0_ctrl = c0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_ctrl = c1; req1_a = a1; req1_b = b1;
        rsp0_ready = r0; rsp1_ready = r1;
        #1;
        g    = (v0 && v1) ? !m_last : v1;
        e_r0 = (m_phase == 0) && v0 && !g;
        e_r1 = (m_phase == 0) && v1 && g;
        e_v0 = (m_phase == 2) && !m_owner;
        e_v1 = (m_phase == 2) && m_owner;
        check_eq("req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
        check_eq("req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});
        check_eq("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, e_v0});
        check_eq("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, e_v1});
        check_eq("alu_ctrl", {28'd0, alu_ctrl_signal}, {28'd0, m_ctrl});
        check_eq("alu_a", alu_a, m_a);
        check_eq("alu_b", alu_b, m_b);
        if (e_v0) begin
            check_eq("rsp0_result", rsp0_result, m_res[0]);
            check_eq("rsp0_zero", {31'd0, rsp0_zero}, {31'd0, m_zero[0]});
        end
        if (e_v1) begin
            check_eq("rsp1_result", rsp1_result, m_res[1]);
            check_eq("rsp1_zero", {31'd0, rsp1_zero}, {31'd0, m_zero[1]});
        end
`ifdef FIREBIRD_ALU_ARB_PERF_EN
        check_eq("perf_grant0", perf_grant0, m_g0);
        check_eq("perf_grant1", perf_grant1, m_g1);
        check_eq("perf_conflict", perf_conflict, m_conf);
`endif
        @(posedge clk);
        if (m_phase == 0 && v0 && v1) m_conf++;
        case (m_phase)
            0: if (e_r0 || e_r1) begin
                   m_owner = g; m_last = g;
                   m_ctrl = g ? c1 : c0; m_a = g ? a1 : a0; m_b = g ? b1 : b0;
                   if (g) m_g1++; else m_g0++;
                   m_phase = 1;
               end
            1: begin
                   m_res[m_owner]  = ref_alu(m_ctrl, m_a, m_b);
                   m_zero[m_owner] = (m_res[m_owner] == '0);
                   m_phase = 2;
               end
            default: if (m_owner ? r1 : r0) m_phase = 0;
        endcase
    endtask

    task automatic idle_cycle(input logic r0, input logic r1);
        cycle(1'b0, 1'b0, 4'h0, '0, '0, 4'h0, '0, '0, r0, r1);
    endtask

    initial begin
        logic [3:0] codes [5];
        codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0010; codes[3] = 4'b0110; codes[4] = 4'b1011;

        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_ctrl = '0; req1_ctrl = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // req0 alone: ADD 5+7
        cycle(1'b1, 1'b0, 4'b0010, 32'd5, 32'd7, 4'h0, '0, '0, 1'b1, 1'b1);
        #1;
        check_eq("t1_alu_ctrl", {28'd0, alu_ctrl_signal}, 32'h2);
        check_eq("t1_alu_a", alu_a, 32'd5);
        idle_cycle(1'b1, 1'b1);
        #1;
        check_eq("t1_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        check_eq("t1_rsp0_result", rsp0_result, 32'd12);
        check_eq("t1_rsp0_zero", {31'd0, rsp0_zero}, 32'd0);
        check_eq("t1_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        idle_cycle(1'b1, 1'b1);

        // Both valid from reset: req0 first, then req1, then req0 again.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 1'b1, 4'b0110, 32'd9, 32'd9, 4'b0001, 32'hF0, 32'h0F, 1'b1, 1'b1);
            #1;
            if (i == 1) begin
                check_eq("t2_rsp0_result", rsp0_result, 32'd0);
                check_eq("t2_rsp0_zero", {31'd0, rsp0_zero}, 32'd1);
            end
            if (i == 4) check_eq("t2_rsp1_result", rsp1_result, 32'hFF);
            if (i == 6) check_eq("t2_third_owner_a", alu_a, 32'd9);
        end
        cycle(1'b0, 1'b1, 4'h0, '0, '0, 4'b0010, 32'd1, 32'd2, 1'b1, 1'b1);
`ifdef FIREBIRD_ALU_ARB_PERF_EN
        #1;
        check_eq("t6_perf_conflict", perf_conflict, 32'd3);
        check_eq("t6_perf_grant0", perf_grant0, 32'd2);
        check_eq("t6_perf_grant1", perf_grant1, 32'd2);
`endif
        repeat (2) idle_cycle(1'b1, 1'b1);

        // Back-pressure on rsp0 while req1 waits.
        do_reset();
        cycle(1'b1, 1'b0, 4'b0010, 32'd100, 32'd23, 4'h0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++)
            cycle(1'b0, 1'b1, 4'h0, '0, '0, 4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 4'h0, '0, '0, 4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 4'h0, '0, '0, 4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 1'b1, 1'b1);
        repeat (3) idle_cycle(1'b1, 1'b1);

        // Reset in the middle of EXEC, then a fresh req1-only request.
        cycle(1'b1, 1'b1, 4'b0010, 32'd3, 32'd4, 4'b0010, 32'd6, 32'd7, 1'b1, 1'b1);
        do_reset();
        idle_cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1, 4'h0, '0, '0, 4'b0110, 32'd50, 32'd8, 1'b1, 1'b1);
        repeat (3) idle_cycle(1'b1, 1'b1);

        // Unknown ctrl passes through untouched.
        cycle(1'b1, 1'b0, 4'b1111, 32'h12345678, 32'h0000FFFF, 4'h0, '0, '0, 1'b1, 1'b1);
        #1;
        check_eq("t5_alu_ctrl", {28'd0, alu_ctrl_signal}, 32'hF);
        idle_cycle(1'b1, 1'b1);
        #1;
        check_eq("t5_rsp0_result", rsp0_result, 32'h12345678 ^ ~32'h0000FFFF);
        idle_cycle(1'b1, 1'b1);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            logic [XLEN-1:0] a0, b0, a1, b1;
            a0 = $urandom; a1 = $urandom;
            b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  codes[$urandom_range(0, 4)], a0, b0,
                  codes[$urandom_range(0, 4)], a1, b1,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
